// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_W data bits, optional parity, 1/2 stop.
// Ports: clk, rst_n, tx_data/tx_valid/tx_ready in, tx line, busy, idle.
module uart_tx_cfg #(
  parameter int FCLK      = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              idle
);

  localparam int DIV = FCLK / BAUD;
  localparam int TW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int IW  = $clog2(DATA_W);

  localparam logic [TW-1:0] T_LAST  = TW'(DIV - 1);
  localparam logic [IW-1:0] I_LAST  = IW'(DATA_W - 1);
  localparam logic          S_LAST  = 1'(STOP_BITS - 1);
  localparam bit            HAS_PAR = (PARITY != 0);
  localparam bit            ODD     = (PARITY == 2);

  if (DATA_W < 5 || DATA_W > 9 ||
      PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      DIV < 2) begin : g_bad_cfg
    $error("uart_tx_cfg: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t            state, state_d;
  logic [TW-1:0]     tmr, tmr_d;
  logic [IW-1:0]     idx, idx_d;
  logic              stp, stp_d;
  logic [DATA_W-1:0] shf, shf_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] hold, hold_d;
  logic              full, full_d;
  logic              tx_q, tx_d;
  logic              bit_end;
  logic              load;
  logic [TW-1:0]     tmr_run;

  assign bit_end = (tmr == '0);
  assign tmr_run = bit_end ? T_LAST : tmr - 1'b1;

  always_comb begin
    state_d = state;
    tmr_d   = tmr;
    idx_d   = idx;
    stp_d   = stp;
    shf_d   = shf;
    par_d   = par_q;
    hold_d  = hold;
    full_d  = full;
    tx_d    = 1'b1;
    load    = 1'b0;

    if (tx_valid && !full) begin
      hold_d = tx_data;
      full_d = 1'b1;
    end

    unique case (state)
      S_IDLE: begin
        tx_d  = 1'b1;
        tmr_d = '0;
        load  = full;
      end
      S_START: begin
        tx_d  = 1'b0;
        tmr_d = tmr_run;
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        tx_d  = shf[idx];
        tmr_d = tmr_run;
        if (bit_end) begin
          if (idx == I_LAST) begin
            state_d = HAS_PAR ? S_PAR : S_STOP;
            stp_d   = 1'b0;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
      S_PAR: begin
        tx_d  = par_q;
        tmr_d = tmr_run;
        if (bit_end) begin
          state_d = S_STOP;
          stp_d   = 1'b0;
        end
      end
      S_STOP: begin
        tx_d  = 1'b1;
        tmr_d = tmr_run;
        if (bit_end) begin
          if (stp == S_LAST) begin
            // a held word starts straight away: no idle gap
            if (full) load = 1'b1;
            else state_d = S_IDLE;
          end else begin
            stp_d = stp + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    // never coincides with an accept: ready is low while full
    if (load) begin
      state_d = S_START;
      tmr_d   = T_LAST;
      shf_d   = hold;
      par_d   = (^hold) ^ ODD;
      full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tmr   <= '0;
      idx   <= '0;
      stp   <= 1'b0;
      shf   <= '0;
      par_q <= 1'b0;
      hold  <= '0;
      full  <= 1'b0;
      tx_q  <= 1'b1;
    end else begin
      state <= state_d;
      tmr   <= tmr_d;
      idx   <= idx_d;
      stp   <= stp_d;
      shf   <= shf_d;
      par_q <= par_d;
      hold  <= hold_d;
      full  <= full_d;
      tx_q  <= tx_d;
    end
  end

  // tx lags the state by one clock, uniformly for every bit
  assign tx       = tx_q;
  assign tx_ready = ~full;
  assign busy     = (state != S_IDLE);
  assign idle     = ~busy & ~full;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three configurations (8N1, 7E1, 9O2) at DIV=10,
// checked against a frame-level model of the serial line.
module tb_uart_tx_cfg;

  localparam int DIV  = 10;
  localparam int LOGN = 8192;

  typedef struct {
    int         s;
    int         e;
    logic [8:0] w;
  } acc_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] vld, rdy, txl, bsy, idl;
  logic [8:0] dat [3];

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  acc_t       accq [$];
  logic [2:0] txlog [LOGN];
  logic [8:0] wq [$];

  always #5 clk = ~clk;

  uart_tx_cfg #(.FCLK(1000), .BAUD(100), .DATA_W(8),
                .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[0][7:0]),
    .tx_valid(vld[0]), .tx_ready(rdy[0]), .tx(txl[0]),
    .busy(bsy[0]), .idle(idl[0]));

  uart_tx_cfg #(.FCLK(1000), .BAUD(100), .DATA_W(7),
                .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[1][6:0]),
    .tx_valid(vld[1]), .tx_ready(rdy[1]), .tx(txl[1]),
    .busy(bsy[1]), .idle(idl[1]));

  uart_tx_cfg #(.FCLK(1000), .BAUD(100), .DATA_W(9),
                .PARITY(2), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[2]),
    .tx_valid(vld[2]), .tx_ready(rdy[2]), .tx(txl[2]),
    .busy(bsy[2]), .idle(idl[2]));

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (vld[i] && rdy[i])
        accq.push_back('{i, cyc + 1, dat[i]});
    cyc <= cyc + 1;
  end

  always @(negedge clk)
    if (cyc < LOGN) txlog[cyc] = txl;

  function automatic int dw(input int s);
    return (s == 0) ? 8 : (s == 1) ? 7 : 9;
  endfunction

  function automatic int pm(input int s);
    return (s == 0) ? 0 : (s == 1) ? 1 : 2;
  endfunction

  function automatic int sb(input int s);
    return (s == 2) ? 2 : 1;
  endfunction

  function automatic int flen(input int s);
    return DIV * (1 + dw(s) + ((pm(s) != 0) ? 1 : 0) + sb(s));
  endfunction

  function automatic logic exp_bit(input int s, input logic [8:0] w,
                                   input int pos);
    int d, ones;
    d = dw(s);
    ones = 0;
    if (pos == 0) return 1'b0;
    if (pos <= d) return w[pos-1];
    if (pm(s) != 0 && pos == d + 1) begin
      for (int i = 0; i < d; i++) ones += int'(w[i]);
      return ((ones % 2) == 1) ^ (pm(s) == 2);
    end
    return 1'b1;
  endfunction

  task automatic drive(input int s, output int c);
    int k, base, guard;
    k = 0;
    guard = 0;
    @(negedge clk);
    c = cyc;
    base = accq.size();
    while (k < wq.size() && guard < 4000) begin
      vld[s] = 1'b1;
      dat[s] = wq[k];
      @(negedge clk);
      guard++;
      if (accq.size() > base) begin
        base = accq.size();
        k++;
      end
    end
    vld[s] = 1'b0;
    dat[s] = 9'($urandom);
    checks++;
    if (k !== wq.size()) begin
      errors++;
      $display("FAIL drive_s%0d: accepted %0d words, required %0d",
               s, k, wq.size());
    end
  endtask

  task automatic check_stream(input int s, input int c, input int b,
                              input string nm);
    int n, fl, t0, tend, bad, first, t, ee;
    logic e, gv, wv;
    n = wq.size();
    fl = flen(s);
    t0 = c + 3;
    tend = t0 + n * fl + 2 * DIV;
    if (tend >= LOGN) begin
      $display("FAIL %s: log overflow at %0d, required < %0d", nm, tend, LOGN);
      $fatal(1);
    end
    while (cyc <= tend) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      bad = 0;
      first = -1;
      gv = 1'b0;
      wv = 1'b0;
      for (int j = 0; j < fl; j++) begin
        t = t0 + i * fl + j;
        e = exp_bit(s, wq[i], j / DIV);
        if (txlog[t][s] !== e) begin
          if (first < 0) begin
            first = j;
            gv = txlog[t][s];
            wv = e;
          end
          bad++;
        end
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s_frame%0d word %h: %0d bad samples, offset %0d got %b want %b",
                 nm, i, wq[i], bad, first, gv, wv);
      end
    end
    bad = 0;
    for (int tt = c + 1; tt < t0; tt++)
      if (txlog[tt][s] !== 1'b1) bad++;
    for (int tt = t0 + n * fl; tt <= tend; tt++)
      if (txlog[tt][s] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_idle_line: %0d low samples, required 0", nm, bad);
    end
    checks++;
    if (accq.size() - b !== n) begin
      errors++;
      $display("FAIL %s_accepts: got %0d, required %0d",
               nm, accq.size() - b, n);
    end
    for (int k = 0; k < n && b + k < accq.size(); k++) begin
      ee = (k == 0) ? c + 1 : c + 3 + (k - 1) * fl;
      checks++;
      if (accq[b+k].s != s || accq[b+k].e != ee || accq[b+k].w !== wq[k]) begin
        errors++;
        $display("FAIL %s_accept%0d: edge %0d word %h, required edge %0d word %h",
                 nm, k, accq[b+k].e, accq[b+k].w, ee, wq[k]);
      end
    end
    checks++;
    if (idl[s] !== 1'b1 || bsy[s] !== 1'b0) begin
      errors++;
      $display("FAIL %s_end_idle: idle %b busy %b, required 1 0",
               nm, idl[s], bsy[s]);
    end
  endtask

  task automatic test_reset();
    vld = '0;
    for (int i = 0; i < 3; i++) dat[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (txl !== 3'b111 || rdy !== 3'b111 || bsy !== 3'b000 || idl !== 3'b111) begin
      errors++;
      $display("FAIL reset_held: tx %b ready %b busy %b idle %b, required 111 111 000 111",
               txl, rdy, bsy, idl);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (txl !== 3'b111 || rdy !== 3'b111 || bsy !== 3'b000 || idl !== 3'b111) begin
      errors++;
      $display("FAIL reset_released: tx %b ready %b busy %b idle %b, required 111 111 000 111",
               txl, rdy, bsy, idl);
    end
  endtask

  task automatic test_single_8n1();
    int c, b;
    wq.delete();
    wq.push_back(9'h0A5);
    b = accq.size();
    drive(0, c);
    check_stream(0, c, b, "single_a5");
  endtask

  task automatic test_back_to_back();
    int c, b;
    wq.delete();
    wq.push_back(9'h001);
    wq.push_back(9'h002);
    wq.push_back(9'h003);
    b = accq.size();
    drive(0, c);
    check_stream(0, c, b, "b2b");
  endtask

  task automatic test_even_parity();
    int c, b;
    wq.delete();
    wq.push_back(9'h055);
    b = accq.size();
    drive(1, c);
    check_stream(1, c, b, "even_55");
    wq.delete();
    wq.push_back(9'h054);
    b = accq.size();
    drive(1, c);
    check_stream(1, c, b, "even_54");
  endtask

  task automatic test_odd_two_stop();
    int c, b;
    wq.delete();
    wq.push_back(9'h1FF);
    b = accq.size();
    drive(2, c);
    check_stream(2, c, b, "odd_1ff");
  endtask

  task automatic test_reset_mid_frame();
    int c, b, bad, t0;
    wq.delete();
    wq.push_back(9'h000);
    wq.push_back(9'h00F);
    drive(0, c);
    t0 = c + 3;
    while (cyc < t0 + 44) @(negedge clk);
    checks++;
    if (txl[0] !== 1'b0 || rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_pre: tx %b ready %b, required 0 0", txl[0], rdy[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (txl[0] !== 1'b1 || rdy[0] !== 1'b1 || idl[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: tx %b ready %b idle %b busy %b, required 1 1 1 0",
               txl[0], rdy[0], idl[0], bsy[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    b = accq.size();
    bad = 0;
    for (int i = 0; i < 3 * flen(0); i++) begin
      @(negedge clk);
      if (txl[0] !== 1'b1 || idl[0] !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: %0d active samples, required 0", bad);
    end
    checks++;
    if (accq.size() !== b) begin
      errors++;
      $display("FAIL rst_mid_accepts: got %0d, required 0", accq.size() - b);
    end
  endtask

  task automatic test_valid_while_full();
    int c, b, b2;
    wq.delete();
    wq.push_back(9'h0C3);
    wq.push_back(9'h05A);
    b = accq.size();
    drive(0, c);
    repeat (20) @(negedge clk);
    checks++;
    if (rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got %b, required 0", rdy[0]);
    end
    b2 = accq.size();
    vld[0] = 1'b1;
    dat[0] = 9'h03C;
    @(negedge clk);
    vld[0] = 1'b0;
    checks++;
    if (accq.size() !== b2) begin
      errors++;
      $display("FAIL full_pulse_taken: got %0d accepts, required 0",
               accq.size() - b2);
    end
    check_stream(0, c, b, "full_pulse");
  endtask

  task automatic test_random();
    int c, b, n;
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 3; s++) begin
        n = $urandom_range(4, 2);
        wq.delete();
        for (int k = 0; k < n; k++)
          wq.push_back(9'($urandom) & 9'((1 << dw(s)) - 1));
        b = accq.size();
        drive(s, c);
        check_stream(s, c, b, "random");
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_8n1();
    test_back_to_back();
    test_even_parity();
    test_odd_two_stop();
    test_reset_mid_frame();
    test_valid_while_full();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
